uart_baud_tx: RTL and testbench
===============================

Name: uart_baud_tx

Overview:
Consumes the free-running 1.8432 MHz UART reference square wave as a level input, all logic clocked by clk_50m. Rising-edge-detects the reference, divides it by a 16-bit divisor latch into a 16x baud tick, and serialises bytes onto tx_out as an 8250-style async frame. Sits between the UART reference clock generator and the 8088 bus-side UART register file, which supplies divisor, line config and bytes through a valid/ready handshake.

Parameters:
DIV_W, 16, divisor latch width
OVERSAMPLE, 16, baud16 ticks per serial bit
SYNC_STAGES, 2, synchroniser flops on ref_clk_in (minimum 2)

Ports:
clk_50m  in  1  system clock, 50 MHz
rst_n  in  1  synchronous reset, active low
ref_clk_in  in  1  1.8432 MHz reference, asynchronous level
divisor  in  DIV_W  baud divisor latch (DLM:DLL)
word_len  in  2  0=5, 1=6, 2=7, 3=8 data bits
stop2  in  1  0=1 stop bit, 1=2 stop bits
par_en  in  1  parity enable (used only with UART_TX_PARITY_EN)
par_even  in  1  1=even, 0=odd parity
tx_data  in  8  byte to send, LSB first
tx_valid  in  1  byte available
tx_ready  out  1  block can accept a byte
tx_busy  out  1  frame in progress
baud16_tick  out  1  one-cycle pulse at 16x baud rate
tx_out  out  1  serial line, idle high

Behaviour:
- Reset: clk_50m and rst_n are the only clock/reset. Reset is synchronous, active low. On reset: tx_out=1, tx_ready=0 in the reset cycle and 1 from the first cycle after release, tx_busy=0, baud16_tick=0, all counters 0, FSM=IDLE, synchroniser flops cleared.
- Reference edge: ref_clk_in passes through SYNC_STAGES flops. ref_tick = last stage & ~previous-sampled value. It is a one-cycle pulse, with 3-cycle latency from the pin edge when SYNC_STAGES=2.
- Divisor: div_cnt decrements on each ref_tick. When div_cnt==0 on a ref_tick, it reloads divisor-1 and pulses baud16_tick for one cycle. divisor==0 is treated as 1.
- Divisor sampling: divisor is sampled only at reload and at frame accept, so a mid-count write takes effect on the next reload.
- Handshake: tx_ready=1 only in IDLE. A byte is accepted on a cycle with tx_valid & tx_ready. On accept, tx_data, word_len, stop2, par_en and par_even are latched. On the next cycle: tx_ready=0, tx_busy=1, tx_out=0 (start bit).
- Accept also reloads div_cnt=divisor-1 and clears os_cnt. This makes the start bit exactly OVERSAMPLE*divisor ref periods, within one ref period of jitter.
- FSM:
  - IDLE -> START on accept.
  - START -> DATA after 16 baud16 ticks.
  - DATA shifts LSB first. Each bit lasts 16 ticks. After bit N-1 (N=5..8) it goes to PARITY if enabled, else STOP.
  - PARITY lasts 16 ticks, then -> STOP.
  - STOP holds tx_out=1 for 16 ticks, or 32 if stop2=1, then -> IDLE.
- os_cnt is 4 bits and wraps 15->0 at each bit boundary. bit_idx is 3 bits.
- Back-to-back: when tx_valid is held high, the next accept occurs in the first IDLE cycle. The line stays high for exactly that one clk cycle between frames.
- Config changes during a frame have no effect until the next accept.
- Reset mid-frame: frame discarded, tx_out=1 on the cycle after rst_n is sampled low.
- baud16_tick runs continuously, including in IDLE.

Optional Feature:
UART_TX_PARITY_EN
- Defined: when latched par_en=1, the PARITY state emits XOR(data bits) for even parity, or its inverse for odd parity. Only the word_len bits take part.
- Undefined: the PARITY state and parity logic are removed. par_en and par_even remain as ports but are ignored, and frames are always without parity.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - word_len codes
  - OVERSAMPLE default
  - the function mapping word_len to bit count
- Sub-module uart_baud_gen contains the synchroniser, edge detect and divisor counter. It outputs baud16_tick and takes a reload strobe from the TX FSM.

Test Plan:
- 1.8432 MHz ref, divisor=12, send 0x55 8N1 -> baud16_tick every 12 ref edges. Line pattern 0,1,0,1,0,1,0,1,0,1, each bit 192 ref periods (~5208 clk), then tx_ready=1.
- divisor=1, send 0xA3 8N1 -> 115200 baud. Bits 0,1,1,0,0,0,1,0,1,1, each bit 16 ref periods.
- word_len=0, stop2=1, send 0xFF -> start bit, five 1s, stop high for 32 ticks. Upper 3 bits never appear on the line.
- tx_valid held with 0x01 then 0x80 -> second accept in the first IDLE cycle. One-cycle high gap between frames, then second start bit.
- rst_n low for one cycle during DATA bit 3 -> tx_out=1, tx_busy=0, FSM=IDLE next cycle, tx_ready=1 the cycle after.
- With UART_TX_PARITY_EN, send 0x07 8E1 -> parity bit 1. Same byte with par_even=0 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the uart_baud_tx transmitter.
//   tx_state_e     : transmit FSM states
//   WL_5..WL_8     : word_len codes (5..8 data bits)
//   OVERSAMPLE_DEF : baud16 ticks per serial bit
//   word_bits()    : word_len code -> number of data bits
//   data_parity()  : parity bit over the active data bits.
//                    Only referenced when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] WL_5 = 2'd0;
   localparam logic [1:0] WL_6 = 2'd1;
   localparam logic [1:0] WL_7 = 2'd2;
   localparam logic [1:0] WL_8 = 2'd3;

   localparam int OVERSAMPLE_DEF = 16;

   function automatic logic [3:0] word_bits(input logic [1:0] wl);
      logic [3:0] n;
      case (wl)
         WL_5:    n = 4'd5;
         WL_6:    n = 4'd6;
         WL_7:    n = 4'd7;
         WL_8:    n = 4'd8;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // Even parity is the XOR of the data bits.
   // Odd parity is its inverse.
   // Bits above the word length are masked off.
   function automatic logic data_parity(input logic [7:0] data,
                                        input logic [1:0] wl,
                                        input logic       even);
      logic [7:0] mask;
      logic       p;
      mask = 8'hFF >> (4'd8 - word_bits(wl));
      p    = ^(data & mask);
      return even ? p : ~p;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- turns the asynchronous UART reference clock into a 16x baud tick.
//   clk_50m     in  system clock
//   rst_n       in  synchronous reset, active low
//   ref_clk_in  in  1.8432 MHz reference, asynchronous level
//   divisor     in  baud divisor latch; 0 behaves as 1
//   reload      in  restart the divisor count from divisor-1 (frame accept)
//   baud16_tick out one-cycle pulse every divisor reference rising edges
module uart_baud_gen #(
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_50m,
   input  logic             rst_n,
   input  logic             ref_clk_in,
   input  logic [DIV_W-1:0] divisor,
   input  logic             reload,
   output logic             baud16_tick
);

   localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   ref_prev_q, ref_prev_d;
   logic                   ref_tick_q, ref_tick_d;
   logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
   logic                   baud16_tick_q, baud16_tick_d;
   logic [DIV_W-1:0]       div_load_s;

   // Synchroniser, rising-edge detect and divisor down-counter.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], ref_clk_in};
      ref_prev_d = sync_q[SYNC_STAGES-1];
      // Registered so that the pin-to-tick latency is 3 cycles with two sync stages.
      ref_tick_d = sync_q[SYNC_STAGES-1] & ~ref_prev_q;
      // The divisor is sampled only here, so a mid-count write waits for the next reload.
      div_load_s = (divisor == DIV_ZERO) ? DIV_ZERO : (divisor - DIV_ONE);
      div_cnt_d     = div_cnt_q;
      baud16_tick_d = 1'b0;
      if (reload) begin
         // Reload wins over a coincident reference tick so that the start bit begins a full period.
         div_cnt_d = div_load_s;
      end else if (ref_tick_q) begin
         if (div_cnt_q == DIV_ZERO) begin
            div_cnt_d     = div_load_s;
            baud16_tick_d = 1'b1;
         end else begin
            div_cnt_d = div_cnt_q - DIV_ONE;
         end
      end else begin
         div_cnt_d = div_cnt_q;
      end
   end

   // Baud generator state register with synchronous active-low reset.
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         sync_q        <= '0;
         ref_prev_q    <= 1'b0;
         ref_tick_q    <= 1'b0;
         div_cnt_q     <= DIV_ZERO;
         baud16_tick_q <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         ref_prev_q    <= ref_prev_d;
         ref_tick_q    <= ref_tick_d;
         div_cnt_q     <= div_cnt_d;
         baud16_tick_q <= baud16_tick_d;
      end
   end

   assign baud16_tick = baud16_tick_q;

endmodule

// File: rtl/uart_baud_tx.sv
// uart_baud_tx -- 8250-style asynchronous serial transmitter with a reference-clock baud divider.
//
// Build option: define UART_TX_PARITY_EN to include the parity stage.
// Without this macro, par_en and par_even are ignored and frames carry no parity bit.
//
//   clk_50m     in  system clock, 50 MHz
//   rst_n       in  synchronous reset, active low
//   ref_clk_in  in  1.8432 MHz reference, asynchronous level
//   divisor     in  baud divisor latch (DLM:DLL)
//   word_len    in  0=5, 1=6, 2=7, 3=8 data bits
//   stop2       in  0=1 stop bit, 1=2 stop bits
//   par_en      in  parity enable
//   par_even    in  1=even, 0=odd parity
//   tx_data     in  byte to send, LSB first
//   tx_valid    in  byte available
//   tx_ready    out block can accept a byte (IDLE only)
//   tx_busy     out frame in progress
//   baud16_tick out one-cycle pulse at 16x baud rate, free running
//   tx_out      out serial line, idle high
module uart_baud_tx
   import uart_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_50m,
   input  logic             rst_n,
   input  logic             ref_clk_in,
   input  logic [DIV_W-1:0] divisor,
   input  logic [1:0]       word_len,
   input  logic             stop2,
   input  logic             par_en,
   input  logic             par_even,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_busy,
   output logic             baud16_tick,
   output logic             tx_out
);

   // os_cnt is 4 bits wide, so OVERSAMPLE must not exceed 16.
   localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

   tx_state_e  state_q, state_d;
   logic [3:0] os_cnt_q, os_cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic [1:0] wl_q, wl_d;
   logic       stop2_q, stop2_d;
   logic       stop_second_q, stop_second_d;
   logic       tx_out_q, tx_out_d;
   logic       tx_ready_q, tx_ready_d;
   logic       tx_busy_q, tx_busy_d;
   logic       accept_s, os_wrap_s, baud16_tick_s;
   logic [2:0] last_idx_s;
`ifdef UART_TX_PARITY_EN
   logic       par_en_q, par_en_d;
   logic       par_bit_q, par_bit_d;
`else
   logic       par_cfg_unused_s;
   assign par_cfg_unused_s = par_en ^ par_even;
`endif

   uart_baud_gen #(
      .DIV_W       (DIV_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_baud_gen (
      .clk_50m     (clk_50m),
      .rst_n       (rst_n),
      .ref_clk_in  (ref_clk_in),
      .divisor     (divisor),
      .reload      (accept_s),
      .baud16_tick (baud16_tick_s)
   );

   // Next-state logic for the transmit FSM.
   // Outputs are derived from the next state, so they register alongside the state change.
   always_comb begin
      accept_s      = tx_valid & tx_ready_q;
      os_wrap_s     = baud16_tick_s & (os_cnt_q == OS_LAST);
      last_idx_s    = 3'(word_bits(wl_q) - 4'd1);
      state_d       = state_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      wl_d          = wl_q;
      stop2_d       = stop2_q;
      stop_second_d = stop_second_q;
`ifdef UART_TX_PARITY_EN
      par_en_d      = par_en_q;
      par_bit_d     = par_bit_q;
`endif
      if (state_q == ST_IDLE) begin
         os_cnt_d = 4'd0;
      end else if (os_wrap_s) begin
         os_cnt_d = 4'd0;
      end else if (baud16_tick_s) begin
         os_cnt_d = os_cnt_q + 4'd1;
      end else begin
         os_cnt_d = os_cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d       = ST_START;
               bit_idx_d     = 3'd0;
               shift_d       = tx_data;
               wl_d          = word_len;
               stop2_d       = stop2;
               stop_second_d = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_en_d      = par_en;
               par_bit_d     = data_parity(tx_data, word_len, par_even);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (os_wrap_s) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (os_wrap_s) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == last_idx_s) begin
                  bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                  end else begin
                     state_d = ST_STOP;
                  end
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (os_wrap_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (os_wrap_s) begin
               // A second stop bit simply repeats the 16-tick stop period once.
               if (stop2_q && !stop_second_q) begin
                  stop_second_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_IDLE:   tx_out_d = 1'b1;
         ST_START:  tx_out_d = 1'b0;
         ST_DATA:   tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_out_d = par_bit_q;
`endif
         ST_STOP:   tx_out_d = 1'b1;
         default:   tx_out_d = 1'b1;
      endcase
      tx_ready_d = (state_d == ST_IDLE);
      tx_busy_d  = (state_d != ST_IDLE);
   end

   // Transmit FSM state and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         os_cnt_q      <= 4'd0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'd0;
         wl_q          <= 2'd0;
         stop2_q       <= 1'b0;
         stop_second_q <= 1'b0;
         tx_out_q      <= 1'b1;
         tx_ready_q    <= 1'b0;
         tx_busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q      <= 1'b0;
         par_bit_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         os_cnt_q      <= os_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         wl_q          <= wl_d;
         stop2_q       <= stop2_d;
         stop_second_q <= stop_second_d;
         tx_out_q      <= tx_out_d;
         tx_ready_q    <= tx_ready_d;
         tx_busy_q     <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
         par_en_q      <= par_en_d;
         par_bit_q     <= par_bit_d;
`endif
      end
   end

   assign tx_out      = tx_out_q;
   assign tx_ready    = tx_ready_q;
   assign tx_busy     = tx_busy_q;
   assign baud16_tick = baud16_tick_s;

endmodule

// File: tb/tb_uart_baud_tx.sv
// tb_uart_baud_tx -- self-checking bench for uart_baud_tx.
// Expected line bits are pushed to a queue when a byte is offered.
// Mid-bit line samples, timed from the bench's own reference-edge count, are compared against that queue.
module tb_uart_baud_tx;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif

   logic        clk_50m    = 1'b0;
   logic        rst_n      = 1'b0;
   logic        ref_clk_in = 1'b0;
   logic [15:0] divisor    = 16'd12;
   logic [1:0]  word_len   = 2'd3;
   logic        stop2      = 1'b0;
   logic        par_en     = 1'b0;
   logic        par_even   = 1'b0;
   logic [7:0]  tx_data    = 8'd0;
   logic        tx_valid   = 1'b0;
   logic        tx_ready, tx_busy, baud16_tick, tx_out;

   int   n_checks  = 0;
   int   n_pass    = 0;
   int   ref_edges = 0;
   logic exp_q[$];
   logic obs_q[$];

   uart_baud_tx dut (
      .clk_50m     (clk_50m),
      .rst_n       (rst_n),
      .ref_clk_in  (ref_clk_in),
      .divisor     (divisor),
      .word_len    (word_len),
      .stop2       (stop2),
      .par_en      (par_en),
      .par_even    (par_even),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_busy     (tx_busy),
      .baud16_tick (baud16_tick),
      .tx_out      (tx_out)
   );

   initial forever #10 clk_50m = ~clk_50m;      // 50 MHz
   initial forever #271 ref_clk_in = ~ref_clk_in; // ~1.8432 MHz

   always @(posedge ref_clk_in) ref_edges <= ref_edges + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: builds the expected line bits for one frame.
   task automatic push_frame(input logic [7:0] d, input logic [1:0] wl, input logic s2,
                             input logic pe, input logic pev, output int nbits);
      int   nd;
      logic p;
      nd = 5 + int'(wl);
      p  = 1'b0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < nd; i++) begin
         exp_q.push_back(d[i]);
         p = p ^ d[i];
      end
      nbits = 2 + nd;
      if (pe && PAR_BUILT) begin
         exp_q.push_back(pev ? p : ~p);
         nbits++;
      end
      exp_q.push_back(1'b1);
      if (s2) begin
         exp_q.push_back(1'b1);
         nbits++;
      end
   endtask

   // Offers a byte and waits for the accept.
   // On return we are at the first negedge after the accept, and e0 holds the reference-edge count there.
   task automatic send_byte(input logic [7:0] d, input logic [1:0] wl, input logic s2,
                            input logic pe, input logic pev, input bit hold,
                            output bit ok, output int e0);
      int n;
      @(negedge clk_50m);
      tx_data = d; word_len = wl; stop2 = s2; par_en = pe; par_even = pev;
      tx_valid = 1'b1;
      n = 0;
      while (tx_ready !== 1'b1 && n < 2000) begin
         @(negedge clk_50m);
         n++;
      end
      ok = (tx_ready === 1'b1);
      @(negedge clk_50m);
      if (!hold) tx_valid = 1'b0;
      e0 = ref_edges;
   endtask

   // Samples tx_out at the middle of each bit, timed from reference edges counted by the bench.
   task automatic capture_bits(input int first, input int count, input int div, input int e0);
      int target;
      for (int k = first; k < first + count; k++) begin
         target = e0 + (k * 16 + 8) * div;
         while (ref_edges < target) @(negedge clk_50m);
         obs_q.push_back(tx_out);
      end
   endtask

   task automatic wait_ready(input int budget, output bit ok);
      int n;
      n = 0;
      while (tx_ready !== 1'b1 && n < budget) begin
         @(negedge clk_50m);
         n++;
      end
      ok = (tx_ready === 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tx_valid = 1'b0; divisor = 16'd12;
      repeat (4) @(negedge clk_50m);
      n_checks++; if (tx_out !== 1'b1) $display("FAIL reset_tx_out: got %b want 1", tx_out); else n_pass++;
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b want 0", tx_ready); else n_pass++;
      n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b want 0", tx_busy); else n_pass++;
      n_checks++; if (baud16_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", baud16_tick); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk_50m);
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL release_tx_ready: got %b want 1", tx_ready); else n_pass++;
   endtask

   task automatic test_div12();
      int  n, gap, e0, nbits, el;
      bit  ok;
      logic o, e;
      // Skip the first tick because the counter starts from 0 after reset. Then measure one tick period.
      for (int t = 0; t < 2; t++) begin
         n = 0;
         @(negedge clk_50m);
         while (baud16_tick !== 1'b1 && n < 2000) begin @(negedge clk_50m); n++; end
      end
      gap = 0;
      @(negedge clk_50m);
      while (baud16_tick !== 1'b1 && gap < 2000) begin @(negedge clk_50m); gap++; end
      gap++;
      // 12 reference periods of 542 units = 325.2 clk periods.
      n_checks++; if (gap < 324 || gap > 327) $display("FAIL div12_tick_period: got %0d clk want 325..326", gap); else n_pass++;
      push_frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, nbits);
      send_byte(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ok, e0);
      n_checks++; if (!ok) $display("FAIL div12_accept: got timeout want tx_ready"); else n_pass++;
      n_checks++; if (tx_out !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0)
         $display("FAIL div12_start: got out=%b busy=%b ready=%b want 0 1 0", tx_out, tx_busy, tx_ready); else n_pass++;
      capture_bits(0, nbits, 12, e0);
      n = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
         n_checks++; if (o !== e) $display("FAIL div12_bit%0d: got %b want %b", n, o, e); else n_pass++;
         n++;
      end
      wait_ready(20000, ok);
      el = ref_edges - e0;
      n_checks++; if (!ok || el < nbits * 192 - 1 || el > nbits * 192 + 1)
         $display("FAIL div12_frame_len: got %0d ref edges (ready=%b) want %0d", el, ok, nbits * 192); else n_pass++;
   endtask

   task automatic test_div1();
      int  n, e0, nbits, el;
      bit  ok;
      logic o, e;
      @(negedge clk_50m);
      divisor = 16'd1;
      n = 0;
      while (baud16_tick !== 1'b1 && n < 2000) begin @(negedge clk_50m); n++; end
      n_checks++; if (baud16_tick !== 1'b1) $display("FAIL idle_tick: got no tick in %0d clk want tick", n); else n_pass++;
      push_frame(8'hA3, 2'd3, 1'b0, 1'b0, 1'b0, nbits);
      send_byte(8'hA3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ok, e0);
      n_checks++; if (!ok) $display("FAIL div1_accept: got timeout want tx_ready"); else n_pass++;
      capture_bits(0, nbits, 1, e0);
      n = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
         n_checks++; if (o !== e) $display("FAIL div1_bit%0d: got %b want %b", n, o, e); else n_pass++;
         n++;
      end
      wait_ready(2000, ok);
      el = ref_edges - e0;
      n_checks++; if (!ok || el < nbits * 16 - 1 || el > nbits * 16 + 1)
         $display("FAIL div1_frame_len: got %0d ref edges want %0d", el, nbits * 16); else n_pass++;
   endtask

   task automatic test_wl5_stop2();
      int  n, e0, nbits, el;
      bit  ok;
      logic o, e;
      push_frame(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0, nbits);
      send_byte(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, ok, e0);
      n_checks++; if (!ok) $display("FAIL wl5_accept: got timeout want tx_ready"); else n_pass++;
      capture_bits(0, nbits, 1, e0);
      n = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
         n_checks++; if (o !== e) $display("FAIL wl5_bit%0d: got %b want %b", n, o, e); else n_pass++;
         n++;
      end
      wait_ready(2000, ok);
      el = ref_edges - e0;
      n_checks++; if (!ok || el < nbits * 16 - 1 || el > nbits * 16 + 1)
         $display("FAIL wl5_frame_len: got %0d ref edges want %0d", el, nbits * 16); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int  n, e0, e1, nb1, nb2, el;
      bit  ok;
      logic o, e;
      push_frame(8'h01, 2'd3, 1'b0, 1'b0, 1'b0, nb1);
      send_byte(8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, ok, e0);
      n_checks++; if (!ok) $display("FAIL b2b_accept: got timeout want tx_ready"); else n_pass++;
      tx_data = 8'h80;
      push_frame(8'h80, 2'd3, 1'b0, 1'b0, 1'b0, nb2);
      capture_bits(0, nb1, 1, e0);
      n = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
         n_checks++; if (o !== e) $display("FAIL b2b_f1_bit%0d: got %b want %b", n, o, e); else n_pass++;
         n++;
      end
      wait_ready(2000, ok);
      n_checks++; if (!ok || tx_out !== 1'b1) $display("FAIL b2b_gap: got ready=%b out=%b want 1 1", ok, tx_out); else n_pass++;
      @(negedge clk_50m);
      e1 = ref_edges;
      tx_valid = 1'b0;
      n_checks++; if (tx_out !== 1'b0 || tx_ready !== 1'b0)
         $display("FAIL b2b_second_start: got out=%b ready=%b want 0 0", tx_out, tx_ready); else n_pass++;
      capture_bits(0, nb2, 1, e1);
      n = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
         n_checks++; if (o !== e) $display("FAIL b2b_f2_bit%0d: got %b want %b", n, o, e); else n_pass++;
         n++;
      end
      wait_ready(2000, ok);
      el = ref_edges - e1;
      n_checks++; if (!ok || el < nb2 * 16 - 1 || el > nb2 * 16 + 1)
         $display("FAIL b2b_f2_len: got %0d ref edges want %0d", el, nb2 * 16); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int  n, e0, nbits, target;
      bit  ok;
      logic o, e;
      push_frame(8'hA3, 2'd3, 1'b0, 1'b0, 1'b0, nbits);
      send_byte(8'hA3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ok, e0);
      n_checks++; if (!ok) $display("FAIL rstmid_accept: got timeout want tx_ready"); else n_pass++;
      capture_bits(0, 4, 1, e0);
      n = 0;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
         n_checks++; if (o !== e) $display("FAIL rstmid_bit%0d: got %b want %b", n, o, e); else n_pass++;
         n++;
      end
      exp_q.delete();
      // The middle of data bit 3 is frame bit 4. The line is low there for 0xA3.
      target = e0 + 4 * 16 + 8;
      while (ref_edges < target) @(negedge clk_50m);
      rst_n = 1'b0;
      @(negedge clk_50m);
      rst_n = 1'b1;
      n_checks++; if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0)
         $display("FAIL rstmid_after: got out=%b busy=%b ready=%b want 1 0 0", tx_out, tx_busy, tx_ready); else n_pass++;
      @(negedge clk_50m);
      n_checks++; if (tx_ready !== 1'b1 || tx_out !== 1'b1)
         $display("FAIL rstmid_ready: got ready=%b out=%b want 1 1", tx_ready, tx_out); else n_pass++;
   endtask

   // Parity frames. Without the parity build, par_en must be ignored and the frames carry no parity bit.
   task automatic test_parity();
      int  n, e0, nbits, el;
      bit  ok;
      logic o, e;
      for (int pass = 0; pass < 2; pass++) begin
         push_frame(8'h07, 2'd3, 1'b0, 1'b1, (pass == 0), nbits);
         send_byte(8'h07, 2'd3, 1'b0, 1'b1, (pass == 0), 1'b0, ok, e0);
         n_checks++; if (!ok) $display("FAIL par%0d_accept: got timeout want tx_ready", pass); else n_pass++;
         capture_bits(0, nbits, 1, e0);
         n = 0;
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_checks++; if (o !== e) $display("FAIL par%0d_bit%0d: got %b want %b", pass, n, o, e); else n_pass++;
            n++;
         end
         wait_ready(2000, ok);
         el = ref_edges - e0;
         n_checks++; if (!ok || el < nbits * 16 - 1 || el > nbits * 16 + 1)
            $display("FAIL par%0d_frame_len: got %0d ref edges want %0d", pass, el, nbits * 16); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_div12();
      test_div1();
      test_wl5_stop2();
      test_back_to_back();
      test_reset_mid();
      test_parity();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
